// File: rtl/res_collector_if.sv
// res_collector_if
// Bundles the byte-input handshake and the word-output handshake of the
// result collector so the collector and its environment share one port.
// Signal names keep the collector's point of view (_i = into the collector,
// _o = out of the collector).
//
//   in_valid_i    1    byte strobe from the result source
//   in_data_i     8    result byte
//   in_ready_o    1    collector can take a byte or a flush this cycle
//   flush_i       1    close the current partial word and end the group
//   word_valid_o  1    word_o holds a committed word
//   word_ready_i  1    drain stage pops the word
//   word_o        255  {count[6:0], data[247:0]}
//   word_last_o   1    final word of a group
//   words_sent_o  32   words popped since reset, wrapping
//
// Modports: slave = the collector, master = source/drain side.

interface res_collector_if;

   logic         in_valid_i;
   logic [7:0]   in_data_i;
   logic         in_ready_o;
   logic         flush_i;
   logic         word_valid_o;
   logic         word_ready_i;
   logic [254:0] word_o;
   logic         word_last_o;
   logic [31:0]  words_sent_o;

   // Collector side of the bundle
   modport slave (
      input  in_valid_i,
      input  in_data_i,
      input  flush_i,
      input  word_ready_i,
      output in_ready_o,
      output word_valid_o,
      output word_o,
      output word_last_o,
      output words_sent_o
   );

   // Byte source and word drain side of the bundle
   modport master (
      output in_valid_i,
      output in_data_i,
      output flush_i,
      output word_ready_i,
      input  in_ready_o,
      input  word_valid_o,
      input  word_o,
      input  word_last_o,
      input  words_sent_o
   );

endinterface

// File: rtl/res_collector.sv
// res_collector
// Packs the result byte stream into 255-bit words {count[6:0], data[247:0]},
// LSB-first, marks every WORDS_PER_GROUP-th word (or a flushed word) as the
// last of its group, and hands words out through a 2-entry FIFO with a
// valid/ready port.
//
// Ports:
//   clk_i    in  1   clock
//   reset_i  in  1   synchronous, active-high reset
//   bus      res_collector_if.slave (byte input, flush, word output, counter)
//
// Parameters:
//   BYTES_PER_WORD   data bytes per word, 1..31
//   WORDS_PER_GROUP  words per group

module res_collector #(
   parameter int BYTES_PER_WORD  = 31,
   parameter int WORDS_PER_GROUP = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   res_collector_if.slave   bus
);

   localparam int GW = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1;
   localparam logic [5:0]    FullCnt = 6'(BYTES_PER_WORD);
   localparam logic [GW-1:0] LastIdx = GW'(WORDS_PER_GROUP - 1);

   typedef enum logic {
      ACC_EMPTY,
      ACC_FILL
   } accState_e;

   typedef enum logic [1:0] {
      FIFO_EMPTY,
      FIFO_ONE,
      FIFO_FULL
   } fifoState_e;

   accState_e      accState_q, accState_d;
   logic [5:0]     byteCnt_q, byteCnt_d;
   logic [247:0]   acc_q, acc_d;
   logic [GW-1:0]  groupIdx_q, groupIdx_d;

   fifoState_e     fifoState_q, fifoState_d;
   logic [254:0]   headWord_q, headWord_d;
   logic           headLast_q, headLast_d;
   logic [254:0]   tailWord_q, tailWord_d;
   logic           tailLast_q, tailLast_d;
   logic [31:0]    wordsSent_q, wordsSent_d;

   logic           popNow;
   logic           inReady;
   logic           acceptByte;
   logic           takeFlush;
   logic [5:0]     filledCnt;
   logic [247:0]   filledAcc;
   logic           commit;
   logic [254:0]   commitWord;
   logic           commitLast;

   // Handshake qualifiers. The collector can take input whenever the FIFO
   // has a free slot after this cycle's pop, which guarantees any commit
   // made this cycle has somewhere to go.
   always_comb begin
      popNow     = (fifoState_q != FIFO_EMPTY) && bus.word_ready_i;
      inReady    = !reset_i && ((fifoState_q != FIFO_FULL) || popNow);
      acceptByte = bus.in_valid_i && inReady;
      takeFlush  = bus.flush_i && inReady;
   end

   // Accumulator next state. The incoming byte is merged first so that a
   // flush in the same cycle as a byte (including the word-completing byte)
   // sees the byte as part of the word it closes. Any commit empties the
   // accumulator on the same edge; the group index wraps after a last word.
   always_comb begin
      accState_d = accState_q;
      byteCnt_d  = byteCnt_q;
      acc_d      = acc_q;
      groupIdx_d = groupIdx_q;
      filledAcc  = acc_q;
      filledCnt  = byteCnt_q + {5'b0, acceptByte};
      commit     = 1'b0;
      commitLast = 1'b0;

      if (acceptByte) begin
         for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (byteCnt_q == 6'(b)) begin
               filledAcc[8*b +: 8] = bus.in_data_i;
            end
         end
      end

      commit     = (acceptByte && (filledCnt == FullCnt)) ||
                   (takeFlush && ((accState_q == ACC_FILL) || acceptByte));
      commitLast = takeFlush || (groupIdx_q == LastIdx);
      commitWord = {1'b0, filledCnt, filledAcc};

      if (commit) begin
         accState_d = ACC_EMPTY;
         byteCnt_d  = '0;
         acc_d      = '0;
         groupIdx_d = commitLast ? '0 : groupIdx_q + GW'(1);
      end else if (acceptByte) begin
         accState_d = ACC_FILL;
         byteCnt_d  = filledCnt;
         acc_d      = filledAcc;
      end
   end

   // Output FIFO next state. The head registers drive the output port
   // directly; the tail only holds a word while the head is stalled. In
   // FULL the collector is not ready unless a pop happens, so a push into
   // FULL always coincides with a pop.
   always_comb begin
      fifoState_d = fifoState_q;
      headWord_d  = headWord_q;
      headLast_d  = headLast_q;
      tailWord_d  = tailWord_q;
      tailLast_d  = tailLast_q;
      wordsSent_d = wordsSent_q + 32'(popNow);

      unique case (fifoState_q)
         FIFO_EMPTY: begin
            if (commit) begin
               headWord_d  = commitWord;
               headLast_d  = commitLast;
               fifoState_d = FIFO_ONE;
            end
         end
         FIFO_ONE: begin
            if (commit && popNow) begin
               headWord_d = commitWord;
               headLast_d = commitLast;
            end else if (commit) begin
               tailWord_d  = commitWord;
               tailLast_d  = commitLast;
               fifoState_d = FIFO_FULL;
            end else if (popNow) begin
               fifoState_d = FIFO_EMPTY;
            end
         end
         FIFO_FULL: begin
            if (popNow) begin
               headWord_d = tailWord_q;
               headLast_d = tailLast_q;
               if (commit) begin
                  tailWord_d = commitWord;
                  tailLast_d = commitLast;
               end else begin
                  fifoState_d = FIFO_ONE;
               end
            end
         end
         default: begin
            fifoState_d = FIFO_EMPTY;
         end
      endcase
   end

   // State registers. Reset discards the partial word and every buffered
   // word so nothing from before the reset is ever emitted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         accState_q  <= ACC_EMPTY;
         byteCnt_q   <= '0;
         acc_q       <= '0;
         groupIdx_q  <= '0;
         fifoState_q <= FIFO_EMPTY;
         headWord_q  <= '0;
         headLast_q  <= 1'b0;
         tailWord_q  <= '0;
         tailLast_q  <= 1'b0;
         wordsSent_q <= '0;
      end else begin
         accState_q  <= accState_d;
         byteCnt_q   <= byteCnt_d;
         acc_q       <= acc_d;
         groupIdx_q  <= groupIdx_d;
         fifoState_q <= fifoState_d;
         headWord_q  <= headWord_d;
         headLast_q  <= headLast_d;
         tailWord_q  <= tailWord_d;
         tailLast_q  <= tailLast_d;
         wordsSent_q <= wordsSent_d;
      end
   end

   // Port drive
   assign bus.in_ready_o   = inReady;
   assign bus.word_valid_o = (fifoState_q != FIFO_EMPTY);
   assign bus.word_o       = headWord_q;
   assign bus.word_last_o  = headLast_q;
   assign bus.words_sent_o = wordsSent_q;

endmodule

// File: doc/res_collector.md
# res_collector

Result-return path of the DPI bench: collects the byte stream produced by `bfm` on `res_o` and packs it into 255-bit result words, the same width the host uses for `recv_res` and for each slot of the 10×3×255-bit stimulus packet. Words are grouped in threes to mirror the stimulus packet's 3-slot entries. Words leave through a valid/ready port that a DPI drain stage pops and hands to `recv_res`, one word per pop.

## Interface

Clock `clk_i`, one clock domain. Reset `reset_i` is synchronous and active-high.

Parameters:
- `BYTES_PER_WORD`, default 31: data bytes per word. Legal range is 1..31.
- `WORDS_PER_GROUP`, default 3: number of words per group. `word_last_o` marks the final word of each group.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  byte strobe from the result source.
- `in_data_i`  in  8  result byte (`res_o`).
- `in_ready_o`  out  1  collector can accept a byte or a flush this cycle.
- `flush_i`  in  1  close the current partial word and end the group.
- `word_valid_o`  out  1  `word_o` holds a committed word.
- `word_ready_i`  in  1  drain stage pops the word.
- `word_o`  out  255  `{count[6:0], data[247:0]}`.
- `word_last_o`  out  1  final word of a group.
- `words_sent_o`  out  32  number of words popped since reset; wraps at 2^32.

## Operation

- **Accept.** A byte is accepted when `in_valid_i && in_ready_o`. It is written to `acc[8*cnt +: 8]`, LSB-first, and `cnt` increments.
- **Commit on full word.** When an accepted byte makes `cnt == BYTES_PER_WORD`, the word `{cnt, acc}` is pushed into the output FIFO. Then `acc` and `cnt` clear to 0.
- **Word layout.**
  - `data` bits above `8*cnt` are zero.
  - `count` occupies bits 254:248.
- **Flush.**
  - Sampled only when `in_ready_o` is 1; the requester holds `flush_i` until then.
  - If `cnt > 0` after any same-cycle byte is accepted: commit the partial word with `word_last_o` = 1, and reset the group index to 0.
  - If `cnt == 0` and no byte is accepted that cycle: no effect.
- **Group index.**
  - `gidx` runs 0..WORDS_PER_GROUP-1 and increments on each commit.
  - A word's last flag is 1 when `gidx == WORDS_PER_GROUP-1` or when it was committed by a flush.
  - After a last word, `gidx` returns to 0.
- **Output FIFO.**
  - 2 entries, each holding {255-bit word, last flag}.
  - Push and pop in the same cycle are both legal.
  - `in_ready_o = !reset_i && (fifo_cnt < 2 || pop_this_cycle)`. A commit always has space, so no word is ever dropped.
- **Pop.** A pop occurs when `word_valid_o && word_ready_i`. It increments `words_sent_o`.
- **Accumulator states.**
  - EMPTY (`cnt == 0`).
  - FILL (`0 < cnt < BYTES_PER_WORD`).
  - A commit returns the accumulator to EMPTY in the same edge.
- **FIFO states.**
  - EMPTY → ONE on push.
  - ONE → FULL on push without pop.
  - FULL → ONE on pop without push.
  - ONE → EMPTY on pop without push.
  - Push and pop together leave the state unchanged.

## Timing

- **Reset values** while `reset_i` = 1:
  - `word_valid_o` = 0, `word_o` = 0, `word_last_o` = 0, `words_sent_o` = 0.
  - `in_ready_o` = 0 during reset and 1 in the first cycle after reset.
  - `cnt`, `acc`, `gidx` and the FIFO are cleared.
- **Reset mid-word.** The partial word and any buffered words are discarded and nothing is emitted.
- **Latency.** A commit at edge N makes the word visible on `word_o` with `word_valid_o` = 1 in cycle N+1 when the FIFO was empty. Otherwise the word queues behind the head entry.
- **Hold rule.** `word_o` and `word_last_o` are stable while `word_valid_o && !word_ready_i`.
- **Throughput.** One byte per cycle with `word_ready_i` held at 1. There are no bubbles across word boundaries.
- **Outputs.** `word_o`, `word_valid_o` and `word_last_o` are driven from FIFO head registers. `in_ready_o` is combinational from FIFO state, `word_ready_i` and `reset_i`.

## Test plan

1. Reset, then bytes 0x01..0x1F on consecutive cycles with `word_ready_i` = 1 → one word one cycle after the 31st byte:
   - `word_o[7:0]` = 0x01, `word_o[247:240]` = 0x1F, `word_o[254:248]` = 31.
   - `word_last_o` = 0, `words_sent_o` = 1.
2. 93 bytes, value i mod 256 → three words:
   - Only the third has `word_last_o` = 1.
   - `words_sent_o` = 3, with no stall on `in_ready_o`.
3. Bytes 0xA0..0xA4, then `flush_i` → word with `count` = 5, `word_o[39:0]` = 0xA4A3A2A1A0, zero above bit 39, and `word_last_o` = 1. The next 31 bytes form a word with `word_last_o` = 0, confirming `gidx` restarted at 0.
4. `word_ready_i` = 0, push 62 bytes → two words buffered and `in_ready_o` = 0 from the cycle after the second commit. Extra bytes are held, not lost. Raise `word_ready_i` → words pop in order and `in_ready_o` returns to 1.
5. Two edge cases:
   - `flush_i` with `cnt` = 0 → no word and `words_sent_o` unchanged.
   - `flush_i` asserted in the same cycle as the 31st byte → exactly one word with `count` = 31 and `word_last_o` = 1.
6. Push 10 bytes, assert `reset_i` for 1 cycle, then push 31 bytes 0x40.. → only one word is emitted, with `word_o[7:0]` = 0x40 and `count` = 31. `words_sent_o` counts from 0 after reset.
